// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus T-state encoding, bus request bundle, wait limit default.
package cpu_pkg;

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } bus_tstate_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    localparam logic [7:0] BUS_WAIT_MAX_DEFAULT = 8'd255;

endpackage

// File: rtl/mem_bus_seq.sv
// M-cycle bus sequencer: steps one byte read/write through T1..T4 on the
// external memory bus and holds the M-cycle address for the IDU.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; strobes low; idu_addr holds last address
// T1     | address driven on bus_addr/idu_addr; bus_rd raised for reads
// T2     | read strobe held; write strobe and write data driven
// T3     | strobes held; bus_wait stalls here, bounded by WAIT_LIMIT
// T4     | strobes low; rsp_valid/mcycle_end pulse; next request accepted
module mem_bus_seq
    import cpu_pkg::*;
#(
    parameter bit          IDLE_HOLD_ADDR = 1'b1,
    parameter int unsigned WAIT_LIMIT     = BUS_WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic [15:0] idu_addr,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_wait,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  tstate,
    output logic        mcycle_end,
    output logic        wait_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4
    } seq_state_t;

    // Counter value on the wait cycle that exhausts the limit.
    localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_LIMIT - 1);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    bus_tstate_t w_tstate;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_timeout_hit;

    bus_req_t    r_req;
    logic [15:0] r_bus_addr;
    logic [15:0] r_idu_addr;
    logic        r_bus_rd;
    logic        r_bus_wr;
    logic [7:0]  r_bus_wdata;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic [7:0]  r_wait_cnt;
    logic        r_wait_timeout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, T-state reporting and request handshake.
    always_comb begin
        w_next_state  = r_state;
        w_tstate      = T1;
        w_req_ready   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = S_T1;
                end
            end
            S_T1: begin
                w_tstate     = T1;
                w_next_state = S_T2;
            end
            S_T2: begin
                w_tstate     = T2;
                w_next_state = S_T3;
            end
            S_T3: begin
                w_tstate = T3;
                if (bus_wait) begin
                    if (r_wait_cnt == LP_WAIT_LAST) begin
                        w_timeout_hit = 1'b1;
                        w_next_state  = S_T4;
                    end
                end else begin
                    w_next_state = S_T4;
                end
            end
            S_T4: begin
                w_tstate     = T4;
                w_req_ready  = 1'b1;
                w_next_state = req_valid ? S_T1 : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_accept = req_valid & w_req_ready;
    end

    // Request latch, bus drivers, wait counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req          <= '0;
            r_bus_addr     <= 16'h0000;
            r_idu_addr     <= 16'h0000;
            r_bus_rd       <= 1'b0;
            r_bus_wr       <= 1'b0;
            r_bus_wdata    <= 8'h00;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 8'h00;
            r_wait_cnt     <= 8'h00;
            r_wait_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_req      <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                r_bus_addr <= req_addr;
                r_idu_addr <= req_addr;
                r_bus_rd   <= ~req_we;
                r_bus_wr   <= 1'b0;
                r_wait_cnt <= 8'h00;
            end else begin
                case (r_state)
                    S_T1: begin
                        if (r_req.we) begin
                            r_bus_wr    <= 1'b1;
                            r_bus_wdata <= r_req.wdata;
                        end
                    end
                    S_T3: begin
                        if (w_next_state == S_T4) begin
                            r_bus_rd    <= 1'b0;
                            r_bus_wr    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            if (w_timeout_hit) begin
                                r_wait_timeout <= 1'b1;
                            end else if (!r_req.we) begin
                                r_rsp_rdata <= bus_rdata;
                            end
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    S_T4: begin
                        // Returning to IDLE: optionally park the address bus at zero.
                        if (!IDLE_HOLD_ADDR) begin
                            r_bus_addr <= 16'h0000;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign req_ready    = w_req_ready;
    assign tstate       = w_tstate;
    assign mcycle_end   = (r_state == S_T4);
    assign idu_addr     = r_idu_addr;
    assign bus_addr     = r_bus_addr;
    assign bus_rd       = r_bus_rd;
    assign bus_wr       = r_bus_wr;
    assign bus_wdata    = r_bus_wdata;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign wait_timeout = r_wait_timeout;

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: default instance plus a WAIT_LIMIT=4,
// address-parking instance for the timeout scenario.
module tb_mem_bus_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        to_req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_wait;
    logic        to_bus_wait;

    logic        req_ready,    to_req_ready;
    logic [15:0] idu_addr,     to_idu_addr;
    logic [15:0] bus_addr,     to_bus_addr;
    logic        bus_rd,       to_bus_rd;
    logic        bus_wr,       to_bus_wr;
    logic [7:0]  bus_wdata,    to_bus_wdata;
    logic        rsp_valid,    to_rsp_valid;
    logic [7:0]  rsp_rdata,    to_rsp_rdata;
    logic [1:0]  tstate,       to_tstate;
    logic        mcycle_end,   to_mcycle_end;
    logic        wait_timeout, to_wait_timeout;

    // Status vector: {tstate, req_ready, bus_rd, bus_wr, rsp_valid, mcycle_end}
    logic [6:0] st, to_st;
    assign st    = {tstate, req_ready, bus_rd, bus_wr, rsp_valid, mcycle_end};
    assign to_st = {to_tstate, to_req_ready, to_bus_rd, to_bus_wr, to_rsp_valid, to_mcycle_end};

    localparam logic [6:0] ST_IDLE = 7'b00_1_0_0_0_0;
    localparam logic [6:0] ST_RT1  = 7'b00_0_1_0_0_0;
    localparam logic [6:0] ST_RT2  = 7'b01_0_1_0_0_0;
    localparam logic [6:0] ST_RT3  = 7'b10_0_1_0_0_0;
    localparam logic [6:0] ST_WT1  = 7'b00_0_0_0_0_0;
    localparam logic [6:0] ST_WT2  = 7'b01_0_0_1_0_0;
    localparam logic [6:0] ST_WT3  = 7'b10_0_0_1_0_0;
    localparam logic [6:0] ST_T4   = 7'b11_1_0_0_1_1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int nr_run = 0;
    int nr_max = 0;

    mem_bus_seq u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .idu_addr(idu_addr), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_wait(bus_wait),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .tstate(tstate),
        .mcycle_end(mcycle_end), .wait_timeout(wait_timeout)
    );

    mem_bus_seq #(.IDLE_HOLD_ADDR(1'b0), .WAIT_LIMIT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(to_req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(to_req_ready), .idu_addr(to_idu_addr), .bus_addr(to_bus_addr),
        .bus_rd(to_bus_rd), .bus_wr(to_bus_wr), .bus_wdata(to_bus_wdata),
        .bus_rdata(bus_rdata), .bus_wait(to_bus_wait),
        .rsp_valid(to_rsp_valid), .rsp_rdata(to_rsp_rdata), .tstate(to_tstate),
        .mcycle_end(to_mcycle_end), .wait_timeout(to_wait_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, sample 1 ns after the edge, track req_ready low runs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!req_ready) nr_run++;
        else nr_run = 0;
        if (nr_run > nr_max) nr_max = nr_run;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL reset_status: got %b exp %b", st, ST_IDLE); end
        n_cmp++; if ({bus_addr, idu_addr, bus_wdata, rsp_rdata, wait_timeout} !== 41'd0) begin n_err++;
            $display("FAIL reset_regs: got %h %h %h %h %b exp all zero", bus_addr, idu_addr, bus_wdata, rsp_rdata, wait_timeout); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL post_reset_status: got %b exp %b", st, ST_IDLE); end
        n_cmp++; if (bus_addr !== 16'h0000) begin n_err++; $display("FAIL post_reset_addr: got %h exp 0000", bus_addr); end
        n_cmp++; if (to_st !== ST_IDLE) begin n_err++; $display("FAIL post_reset_to_status: got %b exp %b", to_st, ST_IDLE); end
    endtask

    task automatic test_read();
        bus_rdata = 8'h5A; req_addr = 16'hC000; req_we = 1'b0; req_wdata = 8'hEE; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (st !== ST_RT1) begin n_err++; $display("FAIL read_t1: got %b exp %b", st, ST_RT1); end
        n_cmp++; if ({bus_addr, idu_addr} !== {16'hC000, 16'hC000}) begin n_err++;
            $display("FAIL read_addr: got %h/%h exp C000/C000", bus_addr, idu_addr); end
        tick();
        n_cmp++; if (st !== ST_RT2) begin n_err++; $display("FAIL read_t2: got %b exp %b", st, ST_RT2); end
        tick();
        n_cmp++; if (st !== ST_RT3) begin n_err++; $display("FAIL read_t3: got %b exp %b", st, ST_RT3); end
        tick();
        n_cmp++; if (st !== ST_T4) begin n_err++; $display("FAIL read_t4: got %b exp %b", st, ST_T4); end
        n_cmp++; if (rsp_rdata !== 8'h5A) begin n_err++; $display("FAIL read_data: got %h exp 5a", rsp_rdata); end
        tick();
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL read_idle: got %b exp %b", st, ST_IDLE); end
        n_cmp++; if ({bus_addr, idu_addr} !== {16'hC000, 16'hC000}) begin n_err++;
            $display("FAIL read_idle_addr: got %h/%h exp C000/C000", bus_addr, idu_addr); end
    endtask

    task automatic test_write();
        bus_rdata = 8'h33; req_addr = 16'hFF80; req_we = 1'b1; req_wdata = 8'hA5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (st !== ST_WT1) begin n_err++; $display("FAIL write_t1: got %b exp %b", st, ST_WT1); end
        n_cmp++; if (bus_addr !== 16'hFF80) begin n_err++; $display("FAIL write_addr: got %h exp ff80", bus_addr); end
        tick();
        n_cmp++; if (st !== ST_WT2) begin n_err++; $display("FAIL write_t2: got %b exp %b", st, ST_WT2); end
        n_cmp++; if (bus_wdata !== 8'hA5) begin n_err++; $display("FAIL write_wdata: got %h exp a5", bus_wdata); end
        tick();
        n_cmp++; if (st !== ST_WT3) begin n_err++; $display("FAIL write_t3: got %b exp %b", st, ST_WT3); end
        tick();
        n_cmp++; if (st !== ST_T4) begin n_err++; $display("FAIL write_t4: got %b exp %b", st, ST_T4); end
        n_cmp++; if ({rsp_rdata, bus_wdata} !== {8'h5A, 8'hA5}) begin n_err++;
            $display("FAIL write_t4_data: got rdata %h wdata %h exp 5a a5", rsp_rdata, bus_wdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int t_first;
        nr_run = 0; nr_max = 0;
        bus_rdata = 8'h11; req_addr = 16'h0100; req_we = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({st, rsp_rdata} !== {ST_T4, 8'h11}) begin n_err++;
            $display("FAIL b2b_first_t4: got %b/%h exp %b/11", st, rsp_rdata, ST_T4); end
        t_first = cyc;
        req_addr = 16'h0101; req_valid = 1'b1; bus_rdata = 8'h22;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({st, bus_addr} !== {ST_RT1, 16'h0101}) begin n_err++;
            $display("FAIL b2b_second_t1: got %b/%h exp %b/0101", st, bus_addr, ST_RT1); end
        repeat (3) tick();
        n_cmp++; if ({st, rsp_rdata} !== {ST_T4, 8'h22}) begin n_err++;
            $display("FAIL b2b_second_t4: got %b/%h exp %b/22", st, rsp_rdata, ST_T4); end
        n_cmp++; if (cyc - t_first !== 4) begin n_err++; $display("FAIL b2b_spacing: got %0d exp 4", cyc - t_first); end
        tick();
        n_cmp++; if (nr_max !== 3) begin n_err++; $display("FAIL b2b_ready_gap: got %0d exp 3", nr_max); end
    endtask

    task automatic test_wait_stall();
        int t0;
        bit got;
        bus_rdata = 8'h77; req_addr = 16'h2000; req_we = 1'b0; req_valid = 1'b1;
        bus_wait = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (st !== ST_RT2) begin n_err++; $display("FAIL stall_t2: got %b exp %b", st, ST_RT2); end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (st !== ST_RT3) begin n_err++; $display("FAIL stall_t3_%0d: got %b exp %b", i, st, ST_RT3); end
            bus_rdata = 8'h90 + 8'(i);
            tick();
        end
        n_cmp++; if (st !== ST_RT3) begin n_err++; $display("FAIL stall_t3_last: got %b exp %b", st, ST_RT3); end
        bus_wait = 1'b0; bus_rdata = 8'hC3;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (rsp_valid) got = 1'b1;
        end
        bus_rdata = 8'h00;
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL stall_rsp_seen: got %b exp 1", got); end
        n_cmp++; if (cyc - t0 !== 7) begin n_err++; $display("FAIL stall_latency: got %0d exp 7", cyc - t0); end
        n_cmp++; if ({rsp_rdata, wait_timeout} !== {8'hC3, 1'b0}) begin n_err++;
            $display("FAIL stall_data: got %h/%b exp c3/0", rsp_rdata, wait_timeout); end
        tick();
    endtask

    task automatic test_timeout();
        req_addr = 16'h3000; req_we = 1'b0; to_req_valid = 1'b1; to_bus_wait = 1'b1;
        tick();
        to_req_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if ({to_st, to_wait_timeout} !== {ST_RT3, 1'b0}) begin n_err++;
            $display("FAIL to_enter_t3: got %b/%b exp %b/0", to_st, to_wait_timeout, ST_RT3); end
        repeat (3) tick();
        n_cmp++; if ({to_st, to_wait_timeout} !== {ST_RT3, 1'b0}) begin n_err++;
            $display("FAIL to_still_t3: got %b/%b exp %b/0", to_st, to_wait_timeout, ST_RT3); end
        tick();
        n_cmp++; if ({to_st, to_wait_timeout} !== {ST_T4, 1'b1}) begin n_err++;
            $display("FAIL to_forced_t4: got %b/%b exp %b/1", to_st, to_wait_timeout, ST_T4); end
        to_bus_wait = 1'b0;
        tick();
        n_cmp++; if ({to_bus_addr, to_idu_addr, to_wait_timeout} !== {16'h0000, 16'h3000, 1'b1}) begin n_err++;
            $display("FAIL to_idle: got %h/%h/%b exp 0000/3000/1", to_bus_addr, to_idu_addr, to_wait_timeout); end
        req_addr = 16'h3001; bus_rdata = 8'h4E; to_req_valid = 1'b1;
        tick();
        to_req_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({to_st, to_rsp_rdata, to_wait_timeout} !== {ST_T4, 8'h4E, 1'b1}) begin n_err++;
            $display("FAIL to_sticky: got %b/%h/%b exp %b/4e/1", to_st, to_rsp_rdata, to_wait_timeout, ST_T4); end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        req_addr = 16'h4000; req_we = 1'b0; bus_rdata = 8'h66; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (st !== ST_RT2) begin n_err++; $display("FAIL rmid_t2: got %b exp %b", st, ST_RT2); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL rmid_async: got %b exp %b", st, ST_IDLE); end
        n_cmp++; if ({bus_addr, idu_addr, rsp_rdata, to_wait_timeout} !== 41'd0) begin n_err++;
            $display("FAIL rmid_regs: got %h/%h/%h/%b exp zero", bus_addr, idu_addr, rsp_rdata, to_wait_timeout); end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rmid_no_rsp: got %0d pulses exp 0", pulses); end
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL rmid_idle: got %b exp %b", st, ST_IDLE); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; to_req_valid = 1'b0;
        req_we = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
        bus_rdata = 8'h00; bus_wait = 1'b0; to_bus_wait = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_wait_stall();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_seq.md
Name: mem_bus_seq

Overview:
- M-cycle bus sequencer between the CPU control unit and the external memory bus.
- Accepts one byte read or write request per M-cycle and steps it through four T-states (T1..T4).
- Drives the address, read/write strobes and write data onto the bus, and returns the read data.
- Holds the latched 16-bit address on `idu_addr`, which feeds the IDU `data_in` so the IDU can compute the post-increment, decrement or offset value in the same M-cycle.

Parameters:
- IDLE_HOLD_ADDR, 1: 1 = `bus_addr` keeps the last address while idle; 0 = `bus_addr` returns to 16'h0000 while idle.
- WAIT_LIMIT, 255: maximum consecutive T3 wait cycles before the timeout flag is set. Legal range 1..255.

Ports:
- clk  in  1  system clock, one T-state per rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  request address.
- req_wdata  in  8  write data.
- req_ready  out  1  sequencer can accept a request this cycle.
- idu_addr  out  16  latched address of the current M-cycle, to the IDU `data_in`.
- bus_addr  out  16  external address bus.
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_wdata  out  8  external write data.
- bus_rdata  in  8  external read data.
- bus_wait  in  1  slave stall request, honoured in T3 only.
- rsp_valid  out  1  one-cycle pulse: M-cycle complete.
- rsp_rdata  out  8  read data; valid while `rsp_valid` = 1, held afterwards.
- tstate  out  2  current T-state (`bus_tstate_t`).
- mcycle_end  out  1  high in T4.
- wait_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset is asynchronous and active-low and fully asynchronous. On assertion, every register takes its reset value immediately:
  - state = IDLE
  - `bus_rd` = 0, `bus_wr` = 0
  - `bus_addr` = 0, `idu_addr` = 0, `bus_wdata` = 0
  - `rsp_valid` = 0, `rsp_rdata` = 0
  - `mcycle_end` = 0, `wait_timeout` = 0
  - `tstate` = T1 encoding (2'd0)
- Reset asserted mid M-cycle aborts the transfer: strobes drop at once, no response is issued, and no partial data is retained.
- States: IDLE, T1, T2, T3, T4.
- `req_ready` = 1 in IDLE and in T4; 0 in all other states.
- Accept: `req_valid` && `req_ready` at a rising edge latches `req_addr`, `req_we` and `req_wdata`. The next state is T1.
- T1: `bus_addr` = `idu_addr` = latched address. `bus_rd` = ~we.
- T2: `bus_rd` stays asserted for a read. For a write, `bus_wr` = 1 and `bus_wdata` = latched data.
- T3:
  - Strobes are held.
  - If `bus_wait` = 1, stay in T3 and increment the wait counter.
  - When the counter reaches WAIT_LIMIT, set `wait_timeout` and force the transition to T4.
  - Otherwise, on the edge leaving T3, capture `bus_rdata` into `rsp_rdata` (reads only; writes leave `rsp_rdata` unchanged).
- T4:
  - `bus_rd` = `bus_wr` = 0; `bus_wdata` is held.
  - `rsp_valid` = 1 and `mcycle_end` = 1 for exactly one cycle.
  - If a new request is accepted, go to T1; otherwise go to IDLE.
- Back-to-back requests give a 4-cycle M-cycle with no bubble. Latency from accept to `rsp_valid` = 4 cycles plus the number of wait cycles.
- `bus_wait` is ignored outside T3. The wait counter is 8 bits and clears on entry to T1.
- IDLE:
  - Strobes = 0.
  - `bus_addr` follows IDLE_HOLD_ADDR.
  - `idu_addr` holds its last value so the IDU output stays stable for write-back.
- `req_*` inputs are don't-care when no accept occurs.
- Read and write are mutually exclusive per M-cycle; `bus_rd` and `bus_wr` are never 1 together.
- `tstate` reports T1 = 0, T2 = 1, T3 = 2, T4 = 3. IDLE also reports 0.

Decomposition:
- `cpu_pkg` (shared package) gains:
  - `bus_tstate_t` enum: T1, T2, T3, T4 = 2'd0..2'd3.
  - `bus_req_t` packed struct: we, addr[15:0], wdata[7:0].
  - Constant `BUS_WAIT_MAX_DEFAULT` = 8'd255.
- The IDLE state is internal to the module and is not part of the package enum.
- No sub-module: the FSM, request latch and wait counter stay in one module.

Test Plan:
- Reset: hold `rst_n` = 0, then release → `req_ready` = 1, `bus_rd` = `bus_wr` = 0, `bus_addr` = 16'h0000, `rsp_valid` = 0. Assert `rst_n` = 0 mid-T2 of a read → `bus_rd` drops the same cycle and no `rsp_valid` is issued.
- Read: request addr 16'hC000, `bus_rdata` = 8'h5A, no wait.
  - `bus_rd` high for T1..T3.
  - `idu_addr` = 16'hC000 from T1.
  - `rsp_valid` exactly 4 cycles after accept with `rsp_rdata` = 8'h5A.
- Write: request addr 16'hFF80, data 8'hA5.
  - `bus_wr` high in T2..T3 only.
  - `bus_wdata` = 8'hA5.
  - `rsp_valid` pulses in T4.
  - `rsp_rdata` keeps its previous value.
- Back-to-back: reads at 16'h0100 then 16'h0101 presented in T4.
  - Second T1 follows the first T4 directly.
  - Two `rsp_valid` pulses 4 cycles apart.
  - `req_ready` never deasserts for more than 3 cycles.
- Wait stall: `bus_wait` = 1 for 3 cycles in T3 of a read → T3 lasts 4 cycles. `rsp_valid` arrives 7 cycles after accept. `rsp_rdata` equals `bus_rdata` sampled on the last T3 cycle.
- Timeout: WAIT_LIMIT = 4 with `bus_wait` held at 1 → T4 is forced after 4 wait cycles and `wait_timeout` = 1, remaining set until reset.
